// File: rtl/levelsync_filt.sv
// Multi-bit level synchroniser into clk_dest with per-channel stability filter
// and registered rise/fall pulses. Channels are independent; no bus coherency.
`timescale 1ns/1ps
module levelsync_filt #(
  parameter int               WIDTH         = 1,
  parameter int               SYNC_STAGES   = 2,
  parameter int               FILTER_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}}
) (
  input  logic             clk_dest,
  input  logic             rst_dest,
  input  logic [WIDTH-1:0] src_data,
  output logic [WIDTH-1:0] dest_data,
  output logic [WIDTH-1:0] dest_rise,
  output logic [WIDTH-1:0] dest_fall,
  output logic [WIDTH-1:0] dest_pending
);

  // A zero-cycle filter still needs a one-bit counter to keep the logic regular.
  localparam int               CNT_W   = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("levelsync_filt: SYNC_STAGES must be at least 2");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    // Single named array per channel so ASYNC_REG / don't-touch can target it.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   data_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   sync_out;

    always_ff @(posedge clk_dest) begin
      if (rst_dest) begin
        sync_q <= {SYNC_STAGES{RESET_VALUE[i]}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], src_data[i]};
      end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_dest) begin
      if (rst_dest) begin
        data_q <= RESET_VALUE[i];
        cnt_q  <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (sync_out == data_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
          // Candidate held long enough: commit it and flag the direction.
          data_q <= sync_out;
          rise_q <= sync_out;
          fall_q <= ~sync_out;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign dest_data[i]    = data_q;
    assign dest_rise[i]    = rise_q;
    assign dest_fall[i]    = fall_q;
    assign dest_pending[i] = |cnt_q;
  end

endmodule

// File: tb/tb_levelsync_filt.sv
// Bench for levelsync_filt: three configurations driven from one initial block,
// expected per-cycle outputs queued at stimulus time and popped on each edge.
`timescale 1ns/1ps
module tb_levelsync_filt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // b: W=1 S=2 F=0   c: W=4 S=2 F=3 RV=1010   d: W=8 S=3 F=0
  logic       src_b = 1'b0;
  logic       data_b, rise_b, fall_b, pend_b;
  logic [3:0] src_c = 4'b1010;
  logic [3:0] data_c, rise_c, fall_c, pend_c;
  logic [7:0] src_d = 8'h00;
  logic [7:0] data_d, rise_d, fall_d, pend_d;

  levelsync_filt #(.WIDTH(1), .SYNC_STAGES(2), .FILTER_CYCLES(0), .RESET_VALUE(1'b0)) u_b (
    .clk_dest(clk), .rst_dest(rst), .src_data(src_b),
    .dest_data(data_b), .dest_rise(rise_b), .dest_fall(fall_b), .dest_pending(pend_b));

  levelsync_filt #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(3), .RESET_VALUE(4'b1010)) u_c (
    .clk_dest(clk), .rst_dest(rst), .src_data(src_c),
    .dest_data(data_c), .dest_rise(rise_c), .dest_fall(fall_c), .dest_pending(pend_c));

  levelsync_filt #(.WIDTH(8), .SYNC_STAGES(3), .FILTER_CYCLES(0), .RESET_VALUE(8'h00)) u_d (
    .clk_dest(clk), .rst_dest(rst), .src_data(src_d),
    .dest_data(data_d), .dest_rise(rise_d), .dest_fall(fall_d), .dest_pending(pend_d));

  logic [31:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] pk(input logic [7:0] d, input logic [7:0] r,
                                     input logic [7:0] f, input logic [7:0] p);
    return {d, r, f, p};
  endfunction

  function automatic logic [31:0] obs_b();
    return {8'(data_b), 8'(rise_b), 8'(fall_b), 8'(pend_b)};
  endfunction

  function automatic logic [31:0] obs_c();
    return {8'(data_c), 8'(rise_c), 8'(fall_c), 8'(pend_c)};
  endfunction

  function automatic logic [31:0] obs_d();
    return {data_d, rise_d, fall_d, pend_d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst   = 1'b1;
    src_c = 4'b1010;
    for (int k = 0; k < 7; k++) exp_q.push_back(pk(8'hA, 8'h0, 8'h0, 8'h0));
    for (int k = 0; k < 7; k++) begin
      step();
      if (k == 2) rst = 1'b0;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL reset cyc%0d expected queue empty", k);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (obs_c() !== e) begin
          failures++;
          $display("FAIL reset cyc%0d got=%h exp=%h", k, obs_c(), e);
        end
      end
    end
  endtask

  task automatic test_latency();
    logic [31:0] e;
    src_b = 1'b1;
    exp_q.push_back(pk(8'h0, 8'h0, 8'h0, 8'h0));
    exp_q.push_back(pk(8'h0, 8'h0, 8'h0, 8'h0));
    exp_q.push_back(pk(8'h1, 8'h1, 8'h0, 8'h0));
    exp_q.push_back(pk(8'h1, 8'h0, 8'h0, 8'h0));
    for (int k = 0; k < 4; k++) begin
      step();
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL latency cyc%0d expected queue empty", k);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (obs_b() !== e) begin
          failures++;
          $display("FAIL latency edge%0d got=%h exp=%h", k + 1, obs_b(), e);
        end
      end
    end
  endtask

  task automatic test_filter_qualify();
    logic [31:0] e;
    src_c = 4'b1110;
    exp_q.push_back(pk(8'hA, 8'h0, 8'h0, 8'h0));
    exp_q.push_back(pk(8'hA, 8'h0, 8'h0, 8'h0));
    for (int k = 0; k < 3; k++) exp_q.push_back(pk(8'hA, 8'h0, 8'h0, 8'h4));
    exp_q.push_back(pk(8'hE, 8'h4, 8'h0, 8'h0));
    exp_q.push_back(pk(8'hE, 8'h0, 8'h0, 8'h0));
    for (int k = 0; k < 7; k++) begin
      step();
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL qualify cyc%0d expected queue empty", k);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (obs_c() !== e) begin
          failures++;
          $display("FAIL qualify edge%0d got=%h exp=%h", k + 1, obs_c(), e);
        end
      end
    end
  endtask

  task automatic test_glitch_reject();
    logic [31:0] e;
    src_c = 4'b1111;
    exp_q.push_back(pk(8'hE, 8'h0, 8'h0, 8'h0));
    exp_q.push_back(pk(8'hE, 8'h0, 8'h0, 8'h0));
    exp_q.push_back(pk(8'hE, 8'h0, 8'h0, 8'h1));
    exp_q.push_back(pk(8'hE, 8'h0, 8'h0, 8'h1));
    exp_q.push_back(pk(8'hE, 8'h0, 8'h0, 8'h0));
    exp_q.push_back(pk(8'hE, 8'h0, 8'h0, 8'h0));
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 1) src_c = 4'b1110;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL glitch cyc%0d expected queue empty", k);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (obs_c() !== e) begin
          failures++;
          $display("FAIL glitch edge%0d got=%h exp=%h", k + 1, obs_c(), e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    // Return channel c to its reset state before starting the fall candidate.
    rst   = 1'b1;
    src_c = 4'b1010;
    step();
    rst   = 1'b0;
    src_c = 4'b1000;
    exp_q.push_back(pk(8'hA, 8'h0, 8'h0, 8'h0));
    exp_q.push_back(pk(8'hA, 8'h0, 8'h0, 8'h0));
    exp_q.push_back(pk(8'hA, 8'h0, 8'h0, 8'h2));
    exp_q.push_back(pk(8'hA, 8'h0, 8'h0, 8'h2));
    for (int k = 0; k < 4; k++) exp_q.push_back(pk(8'hA, 8'h0, 8'h0, 8'h0));
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 3) begin
        rst   = 1'b1;
        src_c = 4'b1010;
      end
      if (k == 4) rst = 1'b0;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL reset_mid cyc%0d expected queue empty", k);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (obs_c() !== e) begin
          failures++;
          $display("FAIL reset_mid edge%0d got=%h exp=%h", k + 1, obs_c(), e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    // Bit 3 toggles every cycle; a one-cycle mismatch can never reach F+1.
    src_c = 4'b0010;
    for (int k = 0; k < 10; k++) exp_q.push_back(pk(8'hA, 8'h0, 8'h0, 8'h0));
    for (int k = 0; k < 10; k++) begin
      step();
      src_c[3] = ~src_c[3];
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL toggle cyc%0d expected queue empty", k);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ((obs_c() & 32'hFFFF_FF00) !== e) begin
          failures++;
          $display("FAIL toggle edge%0d got=%h exp=%h", k + 1, obs_c() & 32'hFFFF_FF00, e);
        end
      end
    end
    src_c = 4'b1010;
  endtask

  task automatic test_multi_channel();
    logic [31:0] e;
    src_d = 8'hA5;
    for (int k = 0; k < 3; k++) exp_q.push_back(pk(8'h00, 8'h00, 8'h00, 8'h00));
    exp_q.push_back(pk(8'hA5, 8'hA5, 8'h00, 8'h00));
    exp_q.push_back(pk(8'hA5, 8'h00, 8'h00, 8'h00));
    for (int k = 0; k < 5; k++) begin
      step();
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL multi cyc%0d expected queue empty", k);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (obs_d() !== e) begin
          failures++;
          $display("FAIL multi edge%0d got=%h exp=%h", k + 1, obs_d(), e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_filter_qualify();
    test_glitch_reject();
    test_reset_mid();
    test_back_to_back();
    test_multi_channel();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover expected entries=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
